// File: rtl/bus_arbiter.sv
// bus_arbiter: 16-master fair round-robin arbiter driving the registered one-hot AmCMUX select.
// Define ARB_LOCK_TIMEOUT_EN to force release of a lock held for LK_TMO cycles without completing.
// state | meaning
// IDLE  | no owner, parked on master 0
// OWN   | a requesting master owns the bus until its final beat completes
// LOCK  | owner holds the bus through a locked sequence
module bus_arbiter #(
    parameter int NM     = 16,
    parameter int LK_TMO = 64
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic [NM-1:0]         MREQ,
    input  logic                  MmLK,
    input  logic [3:0]            MmRB,
    input  logic                  MsRDY,
    output logic [NM-1:0]         AmCMUX,
    output logic [$clog2(NM)-1:0] AmOWN,
    output logic                  AmBUSY,
    output logic                  AmTMO
);
    localparam int OW = $clog2(NM);

    typedef enum logic [1:0] {S_IDLE, S_OWN, S_LOCK} state_t;

    state_t        state_q, state_d;
    logic [NM-1:0] cmux_q, cmux_d, others;
    logic [OW-1:0] own_q, own_d, rr_q, rr_d;
    logic          busy_q, busy_d;
    logic          rel, release_now, forced;
`ifdef ARB_LOCK_TIMEOUT_EN
    localparam logic [15:0] TMO_LAST = 16'(LK_TMO - 1);
    logic [15:0]   cnt_q, cnt_d;
    logic          tmo_q, tmo_d;
`else
    logic          unused_lk_tmo;
    assign unused_lk_tmo = ^16'(LK_TMO);
`endif

    // First set bit above ptr, wrapping; ptr itself is tried last.
    function automatic logic [OW-1:0] pick(input logic [NM-1:0] req, input logic [OW-1:0] ptr);
        logic [OW-1:0] idx;
        pick = ptr;
        for (int k = NM; k >= 1; k--) begin
            idx = ptr + OW'(k);
            if (req[idx]) pick = idx;
        end
    endfunction

    assign rel = MsRDY & (MmRB == 4'd0) & ~MmLK;

    always_comb begin
        state_d     = state_q;
        own_d       = own_q;
        busy_d      = busy_q;
        rr_d        = rr_q;
        release_now = 1'b0;
        forced      = 1'b0;
        others      = MREQ;
        others[own_q] = 1'b0;
`ifdef ARB_LOCK_TIMEOUT_EN
        cnt_d = cnt_q;
        tmo_d = 1'b0;
`endif
        case (state_q)
            S_IDLE: begin
                if (|MREQ) begin
                    own_d   = pick(MREQ, rr_q);
                    busy_d  = 1'b1;
                    state_d = S_OWN;
                end
            end
            S_OWN: begin
                if (MsRDY & MmLK) begin
                    state_d = S_LOCK;
`ifdef ARB_LOCK_TIMEOUT_EN
                    cnt_d = 16'd0;
`endif
                end else if (rel) begin
                    release_now = 1'b1;
                end
            end
            S_LOCK: begin
                if (rel) begin
                    release_now = 1'b1;
                end
`ifdef ARB_LOCK_TIMEOUT_EN
                else if (cnt_q == TMO_LAST) begin
                    release_now = 1'b1;
                    forced      = 1'b1;
                    tmo_d       = 1'b1;
                end else begin
                    cnt_d = cnt_q + 16'd1;
                end
`endif
            end
            default: state_d = S_IDLE;
        endcase

        // A forced release never hands the bus back to the same owner.
        if (release_now) begin
            rr_d = own_q;
            if (|others) begin
                own_d   = pick(others, own_q);
                state_d = S_OWN;
            end else if (MREQ[own_q] & ~forced) begin
                state_d = S_OWN;
            end else begin
                own_d   = '0;
                busy_d  = 1'b0;
                state_d = S_IDLE;
            end
        end

        cmux_d        = '0;
        cmux_d[own_d] = 1'b1;
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q <= S_IDLE;
            cmux_q  <= NM'(1);
            own_q   <= '0;
            busy_q  <= 1'b0;
            rr_q    <= '1;
`ifdef ARB_LOCK_TIMEOUT_EN
            cnt_q   <= 16'd0;
            tmo_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            cmux_q  <= cmux_d;
            own_q   <= own_d;
            busy_q  <= busy_d;
            rr_q    <= rr_d;
`ifdef ARB_LOCK_TIMEOUT_EN
            cnt_q   <= cnt_d;
            tmo_q   <= tmo_d;
`endif
        end
    end

    assign AmCMUX = cmux_q;
    assign AmOWN  = own_q;
    assign AmBUSY = busy_q;
`ifdef ARB_LOCK_TIMEOUT_EN
    assign AmTMO  = tmo_q;
`else
    assign AmTMO  = 1'b0;
`endif

endmodule

// File: tb/tb_bus_arbiter.sv
// Self-checking bench for bus_arbiter: vector table, hand-written corner sequences, random vs model.
// Timeout expectations follow ARB_LOCK_TIMEOUT_EN when it is defined for the build.
module tb_bus_arbiter;
    localparam int LKT = 8;

    logic        CLK = 1'b0;
    logic        RST;
    logic [15:0] MREQ;
    logic        MmLK;
    logic [3:0]  MmRB;
    logic        MsRDY;
    logic [15:0] AmCMUX;
    logic [3:0]  AmOWN;
    logic        AmBUSY;
    logic        AmTMO;

    int checks = 0;
    int errors = 0;

    int m_owner, m_rr, m_cnt;
    bit m_busy, m_locked, m_tmo;

    typedef struct {
        logic [15:0] mreq;
        logic        lk;
        logic [3:0]  rb;
        logic        rdy;
        logic [15:0] cmux;
        logic [3:0]  own;
        logic        busy;
    } vec_t;

    vec_t tbl[$];

    bus_arbiter #(.NM(16), .LK_TMO(LKT)) dut (
        .CLK(CLK), .RST(RST), .MREQ(MREQ), .MmLK(MmLK), .MmRB(MmRB), .MsRDY(MsRDY),
        .AmCMUX(AmCMUX), .AmOWN(AmOWN), .AmBUSY(AmBUSY), .AmTMO(AmTMO)
    );

    always #5 CLK = ~CLK;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic chk_out(input string nm, input logic [15:0] cm, input logic [3:0] ow,
                           input logic bz, input logic tm);
        chk({nm, "_cmux"}, AmCMUX, cm);
        chk({nm, "_own"}, AmOWN, ow);
        chk({nm, "_busy"}, AmBUSY, bz);
        chk({nm, "_tmo"}, AmTMO, tm);
    endtask

    task automatic set_in(input logic [15:0] rq, input logic lk, input logic [3:0] rb, input logic rdy);
        MREQ = rq; MmLK = lk; MmRB = rb; MsRDY = rdy;
    endtask

    function automatic vec_t v(input logic [15:0] rq, input logic lk, input logic [3:0] rb,
                               input logic rdy, input logic [15:0] cm, input logic [3:0] ow,
                               input logic bz);
        vec_t r;
        r.mreq = rq; r.lk = lk; r.rb = rb; r.rdy = rdy;
        r.cmux = cm; r.own = ow; r.busy = bz;
        return r;
    endfunction

    // Reference model: round-robin by modular search, ownership tracked as plain integers.
    function automatic int first_req(input logic [15:0] req, input int from);
        int i;
        for (int k = 1; k <= 16; k++) begin
            i = (from + k) % 16;
            if (req[i]) return i;
        end
        return -1;
    endfunction

    task automatic model_reset();
        m_owner = 0; m_rr = 15; m_cnt = 0;
        m_busy = 0; m_locked = 0; m_tmo = 0;
    endtask

    task automatic model_step();
        bit rel, forced, do_rel;
        logic [15:0] others;
        m_tmo = 0; forced = 0; do_rel = 0;
        rel = MsRDY && (MmRB == 0) && !MmLK;
        if (!m_busy) begin
            if (MREQ != 0) begin
                m_owner = first_req(MREQ, m_rr);
                m_busy = 1; m_locked = 0;
            end
        end else if (!m_locked && MsRDY && MmLK) begin
            m_locked = 1; m_cnt = 0;
        end else if (rel) begin
            do_rel = 1;
        end else if (m_locked) begin
`ifdef ARB_LOCK_TIMEOUT_EN
            if (m_cnt == LKT - 1) begin
                do_rel = 1; forced = 1; m_tmo = 1;
            end else
`endif
            m_cnt++;
        end
        if (do_rel) begin
            m_rr = m_owner;
            m_locked = 0;
            others = MREQ;
            others[m_owner] = 1'b0;
            if (others != 0) m_owner = first_req(others, m_rr);
            else if (!(MREQ[m_owner] && !forced)) begin
                m_busy = 0; m_owner = 0;
            end
        end
    endtask

    task automatic do_reset();
        set_in(16'h0, 1'b0, 4'd0, 1'b0);
        RST = 1'b1;
        tick();
        tick();
        RST = 1'b0;
        model_reset();
    endtask

    initial begin
        set_in(16'h0, 1'b0, 4'd0, 1'b0);
        RST = 1'b1;
        #2;
        chk_out("por", 16'h0001, 4'd0, 1'b0, 1'b0);
        tick();
        RST = 1'b0;
        model_reset();

        // round robin, single request/drop, retain, burst hold, lock hold
        tbl.push_back(v(16'h0222, 0, 0, 0, 16'h0002, 1, 1));
        tbl.push_back(v(16'h0222, 0, 0, 1, 16'h0020, 5, 1));
        tbl.push_back(v(16'h0222, 0, 0, 1, 16'h0200, 9, 1));
        tbl.push_back(v(16'h0222, 0, 0, 1, 16'h0002, 1, 1));
        tbl.push_back(v(16'h0222, 0, 0, 1, 16'h0020, 5, 1));
        tbl.push_back(v(16'h0000, 0, 0, 1, 16'h0001, 0, 0));
        tbl.push_back(v(16'h0008, 0, 0, 0, 16'h0008, 3, 1));
        tbl.push_back(v(16'h0008, 0, 0, 1, 16'h0008, 3, 1));
        tbl.push_back(v(16'h0000, 0, 0, 1, 16'h0001, 0, 0));
        tbl.push_back(v(16'h0004, 0, 0, 0, 16'h0004, 2, 1));
        tbl.push_back(v(16'h0084, 0, 3, 1, 16'h0004, 2, 1));
        tbl.push_back(v(16'h0084, 0, 2, 0, 16'h0004, 2, 1));
        tbl.push_back(v(16'h0084, 0, 2, 1, 16'h0004, 2, 1));
        tbl.push_back(v(16'h0084, 0, 1, 1, 16'h0004, 2, 1));
        tbl.push_back(v(16'h0084, 0, 0, 1, 16'h0080, 7, 1));
        tbl.push_back(v(16'h0080, 0, 0, 0, 16'h0080, 7, 1));
        tbl.push_back(v(16'h0000, 0, 0, 1, 16'h0001, 0, 0));
        tbl.push_back(v(16'h0010, 0, 0, 0, 16'h0010, 4, 1));
        tbl.push_back(v(16'h0050, 1, 0, 1, 16'h0010, 4, 1));
        tbl.push_back(v(16'h0050, 1, 0, 1, 16'h0010, 4, 1));
        tbl.push_back(v(16'h0050, 1, 2, 1, 16'h0010, 4, 1));
        tbl.push_back(v(16'h0050, 0, 1, 1, 16'h0010, 4, 1));
        tbl.push_back(v(16'h0050, 0, 0, 0, 16'h0010, 4, 1));
        tbl.push_back(v(16'h0050, 0, 0, 1, 16'h0040, 6, 1));
        tbl.push_back(v(16'h0000, 0, 0, 1, 16'h0001, 0, 0));

        for (int i = 0; i < tbl.size(); i++) begin
            set_in(tbl[i].mreq, tbl[i].lk, tbl[i].rb, tbl[i].rdy);
            tick();
            chk_out($sformatf("vec%0d", i), tbl[i].cmux, tbl[i].own, tbl[i].busy, 1'b0);
        end

        // async reset while an owner is granted, then in the middle of a burst
        do_reset();
        set_in(16'h0008, 0, 0, 0);
        tick();
        chk_out("pre_rst1", 16'h0008, 4'd3, 1'b1, 1'b0);
        #3 RST = 1'b1;
        #1 chk_out("async_rst1", 16'h0001, 4'd0, 1'b0, 1'b0);
        tick();
        RST = 1'b0;
        set_in(16'h0004, 0, 0, 0);
        tick();
        set_in(16'h0084, 0, 4'd3, 1);
        tick();
        chk_out("burst_hold", 16'h0004, 4'd2, 1'b1, 1'b0);
        #3 RST = 1'b1;
        #1 chk_out("async_rst2", 16'h0001, 4'd0, 1'b0, 1'b0);
        tick();
        RST = 1'b0;

        // lock with the slave stalled
        do_reset();
        set_in(16'h0010, 0, 0, 0);
        tick();
        set_in(16'h0050, 1, 0, 1);
        tick();
        chk_out("lock_entry", 16'h0010, 4'd4, 1'b1, 1'b0);
        MsRDY = 1'b0;
        for (int c = 1; c <= LKT - 1; c++) begin
            tick();
            chk_out($sformatf("lock_wait%0d", c), 16'h0010, 4'd4, 1'b1, 1'b0);
        end
        tick();
`ifdef ARB_LOCK_TIMEOUT_EN
        chk_out("tmo_fire", 16'h0040, 4'd6, 1'b1, 1'b1);
        tick();
        chk_out("tmo_after", 16'h0040, 4'd6, 1'b1, 1'b0);
`else
        chk_out("lock_held", 16'h0010, 4'd4, 1'b1, 1'b0);
        for (int c = 0; c < 20; c++) tick();
        chk_out("lock_held_long", 16'h0010, 4'd4, 1'b1, 1'b0);
`endif

        // random traffic against the reference model
        do_reset();
        for (int n = 0; n < 3000; n++) begin
            MREQ  = ($urandom_range(0, 7) == 0) ? 16'h0 : 16'($urandom & $urandom);
            MmLK  = ($urandom_range(0, 7) == 0);
            MmRB  = ($urandom_range(0, 2) == 0) ? 4'($urandom_range(1, 15)) : 4'd0;
            MsRDY = ($urandom_range(0, 3) != 0);
            model_step();
            tick();
            chk($sformatf("rnd%0d_cmux", n), AmCMUX, 32'(1) << m_owner);
            chk($sformatf("rnd%0d_own", n), AmOWN, 32'(m_owner));
            chk($sformatf("rnd%0d_busy", n), AmBUSY, 32'(m_busy));
            chk($sformatf("rnd%0d_tmo", n), AmTMO, 32'(m_tmo));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
